// File: rtl/rx232_pd.sv
// rx232_pd: oversampled 8N1 receiver that pairs two bytes into a 16-bit BCD word
// {first, second} and reports framing, BCD-digit and inter-byte timeout errors.
module rx232_pd #(
  parameter int unsigned OSR      = 16,
  parameter int unsigned TMO_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxck,
  input  logic        rxd,
  output logic [15:0] bcd,
  output logic        bcd_vld,
  output logic        bcd_err,
  output logic        frm_err,
  output logic        tmo,
  output logic        busy
);

  localparam int unsigned TCW       = $clog2(OSR);
  localparam int unsigned TMO_TICKS = TMO_BITS * OSR;
  localparam int unsigned TMW       = $clog2(TMO_TICKS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]     rxck_d;
  logic           rxd_m, rxd_s;
  logic           tick;
  logic [1:0]     state, state_nx;
  logic [TCW-1:0] tc, tc_nx;
  logic [2:0]     bc, bc_nx;
  logic [7:0]     sh, sh_nx;
  logic [7:0]     hi, hi_nx;
  logic           cnt, cnt_nx;
  logic [TMW-1:0] tmr, tmr_nx;
  logic           armed, armed_nx;
  logic           rdy, rdy_nx;
  logic [15:0]    bcd_nx;
  logic           vld_nx, berr_nx, ferr_nx, tmo_nx, busy_nx;

  function automatic logic nib_bad(input logic [15:0] w);
    nib_bad = (w[15:12] > 4'd9) | (w[11:8] > 4'd9) | (w[7:4] > 4'd9) | (w[3:0] > 4'd9);
  endfunction

  assign tick = rxck_d[0] & ~rxck_d[1];

  // Next-state and output decode; rdy completes a word one clk after byte 1's stop sample.
  always_comb begin
    state_nx = state;
    tc_nx    = tc;
    bc_nx    = bc;
    sh_nx    = sh;
    hi_nx    = hi;
    cnt_nx   = cnt;
    tmr_nx   = tmr;
    armed_nx = armed;
    rdy_nx   = 1'b0;
    bcd_nx   = bcd;
    vld_nx   = 1'b0;
    berr_nx  = 1'b0;
    ferr_nx  = 1'b0;
    tmo_nx   = 1'b0;
    busy_nx  = busy;

    if (rdy) begin
      bcd_nx  = {hi, sh};
      vld_nx  = 1'b1;
      berr_nx = nib_bad({hi, sh});
      busy_nx = 1'b0;
    end

    if (tick) begin
      case (state)
        S_IDLE: begin
          if (rxd_s) armed_nx = 1'b1;
          if (!rxd_s && armed) begin
            state_nx = S_START;
            tc_nx    = '0;
            tmr_nx   = '0;
            if (!cnt) busy_nx = 1'b1;
          end else if (cnt) begin
            if (tmr == TMW'(TMO_TICKS - 1)) begin
              tmo_nx  = 1'b1;
              cnt_nx  = 1'b0;
              busy_nx = 1'b0;
              tmr_nx  = '0;
            end else begin
              tmr_nx = tmr + TMW'(1);
            end
          end
        end
        S_START: begin
          if (tc == TCW'(OSR / 2 - 1)) begin
            tc_nx = '0;
            if (rxd_s) begin
              state_nx = S_IDLE;
              if (!cnt) busy_nx = 1'b0;
            end else begin
              state_nx = S_DATA;
              bc_nx    = '0;
            end
          end else begin
            tc_nx = tc + TCW'(1);
          end
        end
        S_DATA: begin
          if (tc == TCW'(OSR - 1)) begin
            tc_nx = '0;
            sh_nx = {rxd_s, sh[7:1]};
            bc_nx = bc + 3'd1;
            if (bc == 3'd7) state_nx = S_STOP;
          end else begin
            tc_nx = tc + TCW'(1);
          end
        end
        default: begin
          if (tc == TCW'(OSR - 1)) begin
            tc_nx    = '0;
            state_nx = S_IDLE;
            if (rxd_s) begin
              if (!cnt) begin
                hi_nx  = sh;
                cnt_nx = 1'b1;
                tmr_nx = '0;
              end else begin
                cnt_nx = 1'b0;
                rdy_nx = 1'b1;
              end
            end else begin
              // A low stop bit also blocks restart until the line returns high.
              ferr_nx  = 1'b1;
              cnt_nx   = 1'b0;
              busy_nx  = 1'b0;
              armed_nx = 1'b0;
            end
          end else begin
            tc_nx = tc + TCW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxck_d  <= 2'b00;
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      state   <= S_IDLE;
      tc      <= '0;
      bc      <= '0;
      sh      <= '0;
      hi      <= '0;
      cnt     <= 1'b0;
      tmr     <= '0;
      armed   <= 1'b1;
      rdy     <= 1'b0;
      bcd     <= 16'hffff;
      bcd_vld <= 1'b0;
      bcd_err <= 1'b0;
      frm_err <= 1'b0;
      tmo     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      rxck_d  <= {rxck_d[0], rxck};
      rxd_m   <= rxd;
      rxd_s   <= rxd_m;
      state   <= state_nx;
      tc      <= tc_nx;
      bc      <= bc_nx;
      sh      <= sh_nx;
      hi      <= hi_nx;
      cnt     <= cnt_nx;
      tmr     <= tmr_nx;
      armed   <= armed_nx;
      rdy     <= rdy_nx;
      bcd     <= bcd_nx;
      bcd_vld <= vld_nx;
      bcd_err <= berr_nx;
      frm_err <= ferr_nx;
      tmo     <= tmo_nx;
      busy    <= busy_nx;
    end
  end

endmodule
